usb_tx_encoder: RTL and testbench

Bit-level line encoder for the USB transmitter. It sits directly downstream of the transmit timer. It takes the timer's bit-period strobe, byte-load and end-of-data flags, plus the byte the timer addresses in the transmit buffer. From these it serialises SYNC, the data bytes (LSB first), stuff bits and EOP, NRZI-encodes them and drives the D+/D- pair. It also produces the `bit_sent` pulses and the timer reset/enable that close the loop with the timer.

---
 rtl/usb_tx_encoder.sv | 224 ++++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// USB transmit line encoder: serialises SYNC, data (LSB first), stuff bits
// and EOP, NRZI-encodes them and drives D+/D-.
// Ports:
//   clk, n_rst                   - clock, async active-low reset
//   tx_start                     - packet request (sampled in IDLE only)
//   new_bit, load_byte, eod      - strobes from the transmit timer
//   tx_data[7:0]                 - byte currently addressed in the buffer
//   bit_sent, tim_rst, tim_en    - handshake back to the timer
//   d_plus, d_minus              - line drive
//   tx_busy                      - high whenever not IDLE
module usb_tx_encoder #(
    parameter logic [7:0]  SYNC_BYTE    = 8'h80,
    parameter int unsigned EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic       new_bit,
    input  logic       load_byte,
    input  logic       eod,
    input  logic [7:0] tx_data,
    output logic       bit_sent,
    output logic       tim_rst,
    output logic       tim_en,
    output logic       d_plus,
    output logic       d_minus,
    output logic       tx_busy
);
    localparam int SE0_W = (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
        S_EOP_SE0,
        S_EOP_J
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sync_cnt_q, sync_cnt_d;
    logic               sync_end_q, sync_end_d;
    logic [2:0]         ones_q, ones_d;
    logic [7:0]         sync_sr_q, sync_sr_d;
    logic [6:0]         data_sr_q, data_sr_d;
    logic               reload_q, reload_d;
    logic               eod_q, eod_d;
    logic [SE0_W-1:0]   se0_cnt_q, se0_cnt_d;
    logic               level_q, level_d;
    logic               d_plus_q, d_plus_d;
    logic               d_minus_q, d_minus_d;
    logic               bit_sent_q, bit_sent_d;
    logic               tim_rst_q, tim_rst_d;
    logic               tim_en_q, tim_en_d;
    logic               busy_q, busy_d;

    logic               send_en;
    logic               send_bit;
    logic               eod_now;
    logic               reload_now;

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        sync_end_d = sync_end_q;
        ones_d     = ones_q;
        sync_sr_d  = sync_sr_q;
        data_sr_d  = data_sr_q;
        reload_d   = 1'b0;
        eod_d      = 1'b0;
        se0_cnt_d  = se0_cnt_q;
        level_d    = level_q;
        d_plus_d   = d_plus_q;
        d_minus_d  = d_minus_q;
        bit_sent_d = 1'b0;
        tim_rst_d  = 1'b0;
        tim_en_d   = tim_en_q;
        send_en    = 1'b0;
        send_bit   = 1'b0;
        // A strobe coinciding with new_bit still counts; eod masks a
        // simultaneous load_byte.
        eod_now    = eod_q | eod;
        reload_now = reload_q | (load_byte & ~eod);

        unique case (state_q)
            S_IDLE: begin
                d_plus_d  = 1'b1;
                d_minus_d = 1'b0;
                level_d   = 1'b1;
                if (tx_start) begin
                    tim_rst_d  = 1'b1;
                    tim_en_d   = 1'b1;
                    sync_cnt_d = 3'd0;
                    sync_end_d = 1'b0;
                    ones_d     = 3'd0;
                    sync_sr_d  = SYNC_BYTE;
                    state_d    = S_SYNC;
                end
            end
            S_SYNC: begin
                if (new_bit) begin
                    if (sync_end_q) begin
                        data_sr_d  = tx_data[7:1];
                        send_en    = 1'b1;
                        send_bit   = tx_data[0];
                        bit_sent_d = 1'b1;
                        state_d    = S_DATA;
                    end else begin
                        send_en    = 1'b1;
                        send_bit   = sync_sr_q[0];
                        sync_sr_d  = {1'b0, sync_sr_q[7:1]};
                        sync_cnt_d = sync_cnt_q + 3'd1;
                        sync_end_d = (sync_cnt_q == 3'd7);
                    end
                end
            end
            S_DATA: begin
                eod_d    = eod_now;
                reload_d = reload_now;
                if (new_bit) begin
                    if (ones_q == 3'd6) begin
                        // stuff bit; pending flags survive it
                        send_en  = 1'b1;
                        send_bit = 1'b0;
                    end else if (eod_now) begin
                        eod_d     = 1'b0;
                        reload_d  = 1'b0;
                        se0_cnt_d = '0;
                        d_plus_d  = 1'b0;
                        d_minus_d = 1'b0;
                        state_d   = S_EOP_SE0;
                    end else if (reload_now) begin
                        reload_d   = 1'b0;
                        data_sr_d  = tx_data[7:1];
                        send_en    = 1'b1;
                        send_bit   = tx_data[0];
                        bit_sent_d = 1'b1;
                    end else begin
                        data_sr_d  = {1'b0, data_sr_q[6:1]};
                        send_en    = 1'b1;
                        send_bit   = data_sr_q[0];
                        bit_sent_d = 1'b1;
                    end
                end
            end
            S_EOP_SE0: begin
                if (new_bit) begin
                    if (se0_cnt_q == SE0_W'(EOP_SE0_BITS - 1)) begin
                        d_plus_d  = 1'b1;
                        d_minus_d = 1'b0;
                        level_d   = 1'b1;
                        state_d   = S_EOP_J;
                    end else begin
                        se0_cnt_d = se0_cnt_q + SE0_W'(1);
                    end
                end
            end
            S_EOP_J: begin
                if (new_bit) begin
                    tim_en_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // NRZI: a 0 toggles the line, a 1 holds it; level_q=1 means J
        if (send_en) begin
            level_d   = send_bit ? level_q : ~level_q;
            ones_d    = send_bit ? ones_q + 3'd1 : 3'd0;
            d_plus_d  = level_d;
            d_minus_d = ~level_d;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            sync_cnt_q <= 3'd0;
            sync_end_q <= 1'b0;
            ones_q     <= 3'd0;
            sync_sr_q  <= 8'd0;
            data_sr_q  <= 7'd0;
            reload_q   <= 1'b0;
            eod_q      <= 1'b0;
            se0_cnt_q  <= '0;
            level_q    <= 1'b1;
            d_plus_q   <= 1'b1;
            d_minus_q  <= 1'b0;
            bit_sent_q <= 1'b0;
            tim_rst_q  <= 1'b0;
            tim_en_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
            sync_end_q <= sync_end_d;
            ones_q     <= ones_d;
            sync_sr_q  <= sync_sr_d;
            data_sr_q  <= data_sr_d;
            reload_q   <= reload_d;
            eod_q      <= eod_d;
            se0_cnt_q  <= se0_cnt_d;
            level_q    <= level_d;
            d_plus_q   <= d_plus_d;
            d_minus_q  <= d_minus_d;
            bit_sent_q <= bit_sent_d;
            tim_rst_q  <= tim_rst_d;
            tim_en_q   <= tim_en_d;
            busy_q     <= busy_d;
        end
    end

    assign d_plus   = d_plus_q;
    assign d_minus  = d_minus_q;
    assign bit_sent = bit_sent_q;
    assign tim_rst  = tim_rst_q;
    assign tim_en   = tim_en_q;
    assign tx_busy  = busy_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed testbench for usb_tx_encoder.
// Models the transmit timer and records the line state once per bit period.
module tb_usb_tx_encoder;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic       new_bit = 1'b0;
    logic       load_byte = 1'b0;
    logic       eod = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       bit_sent;
    logic       tim_rst;
    logic       tim_en;
    logic       d_plus;
    logic       d_minus;
    logic       tx_busy;

    int         passed = 0;
    int         total = 0;

    string      line_s;
    string      bs_s;
    int         nbits;
    int         trst_cnt;
    bit         done;
    logic [2:0] start_v;
    logic [7:0] bytes [4];

    localparam int MAXP = 64;

    always #5 clk = ~clk;

    usb_tx_encoder dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .tx_start  (tx_start),
        .new_bit   (new_bit),
        .load_byte (load_byte),
        .eod       (eod),
        .tx_data   (tx_data),
        .bit_sent  (bit_sent),
        .tim_rst   (tim_rst),
        .tim_en    (tim_en),
        .d_plus    (d_plus),
        .d_minus   (d_minus),
        .tx_busy   (tx_busy)
    );

    function automatic string line_ch();
        string c;
        case ({d_plus, d_minus})
            2'b10:   c = "J";
            2'b01:   c = "K";
            2'b00:   c = "0";
            default: c = "X";
        endcase
        return c;
    endfunction

    task automatic tick();
        @(negedge clk);
        if (bit_sent === 1'b1) nbits++;
        if (tim_rst === 1'b1) trst_cnt++;
    endtask

    // Timer model: one new_bit every 8 clk, load_byte/eod after every
    // 8 bit_sent pulses. Stops once tx_busy drops or at abort_at.
    task automatic run_packet(input int nb, input int glitch,
                              input int abort_at);
        bit    want_load;
        bit    want_eod;
        string c;
        line_s   = "";
        bs_s     = "";
        nbits    = 0;
        trst_cnt = 0;
        done     = 1'b0;
        tx_data  = bytes[0];
        @(negedge clk);
        tx_start = 1'b1;
        @(negedge clk);
        start_v  = {tim_rst, tim_en, tx_busy};
        tx_start = 1'b0;
        for (int p = 0; p < MAXP; p++) begin
            if (p == abort_at) return;
            want_load = 1'b0;
            want_eod  = 1'b0;
            new_bit = 1'b1;
            tick();
            new_bit = 1'b0;
            line_s = {line_s, line_ch()};
            if (bit_sent === 1'b1) c = "1";
            else c = ".";
            bs_s = {bs_s, c};
            if (tx_busy === 1'b0) begin
                done = 1'b1;
                break;
            end
            if (bit_sent === 1'b1 && (nbits % 8) == 0) begin
                if (nbits / 8 < nb) begin
                    tx_data   = bytes[nbits / 8];
                    want_load = 1'b1;
                end else begin
                    want_eod = 1'b1;
                end
            end
            tick();
            load_byte = want_load;
            eod       = want_eod;
            tick();
            load_byte = 1'b0;
            eod       = 1'b0;
            if (p == glitch) tx_start = 1'b1;
            tick();
            tx_start = 1'b0;
            repeat (4) tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({d_plus, d_minus, tx_busy, tim_en, tim_rst, bit_sent}
            !== 6'b100000) begin
            $display("FAIL reset_state: got %b expected 100000",
                     {d_plus, d_minus, tx_busy, tim_en, tim_rst, bit_sent});
        end else passed++;
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_zero_byte();
        bytes[0] = 8'h00;
        run_packet(1, -1, -1);
        total++;
        if (start_v !== 3'b111)
            $display("FAIL zero_start: rst/en/busy got %b expected 111",
                     start_v);
        else passed++;
        total++;
        if (line_s != "KJKJKJKKJKJKJKJK00JJ")
            $display("FAIL zero_line: got %s expected %s", line_s,
                     "KJKJKJKKJKJKJKJK00JJ");
        else passed++;
        total++;
        if (bs_s != "........11111111....")
            $display("FAIL zero_bitsent: got %s expected %s", bs_s,
                     "........11111111....");
        else passed++;
        total++;
        if (nbits != 8)
            $display("FAIL zero_count: got %0d expected 8", nbits);
        else passed++;
        total++;
        if (trst_cnt != 0)
            $display("FAIL zero_timrst_width: extra pulses got %0d expected 0",
                     trst_cnt);
        else passed++;
        total++;
        if (done !== 1'b1)
            $display("FAIL zero_done: got %0b expected 1", done);
        else passed++;
        total++;
        if ({tim_en, tx_busy, d_plus, d_minus} !== 4'b0010)
            $display("FAIL zero_idle: en/busy/dp/dm got %b expected 0010",
                     {tim_en, tx_busy, d_plus, d_minus});
        else passed++;
    endtask

    task automatic test_stuff_ff();
        bytes[0] = 8'hFF;
        bytes[1] = 8'hFF;
        run_packet(2, -1, -1);
        total++;
        if (line_s != "KJKJKJKKKKKKKJJJJJJJKKKKKK00JJ")
            $display("FAIL ff_line: got %s expected %s", line_s,
                     "KJKJKJKKKKKKKJJJJJJJKKKKKK00JJ");
        else passed++;
        total++;
        if (bs_s != "........11111.111111.11111....")
            $display("FAIL ff_bitsent: got %s expected %s", bs_s,
                     "........11111.111111.11111....");
        else passed++;
        total++;
        if (nbits != 16)
            $display("FAIL ff_count: got %0d expected 16", nbits);
        else passed++;
        total++;
        if (done !== 1'b1)
            $display("FAIL ff_done: got %0b expected 1", done);
        else passed++;
    endtask

    task automatic test_two_bytes();
        string dec;
        string c;
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        run_packet(2, -1, -1);
        dec = "";
        for (int i = 1; i < line_s.len(); i++) begin
            if (bs_s[i] == "1") begin
                if (line_s[i] == line_s[i-1]) c = "1";
                else c = "0";
                dec = {dec, c};
            end
        end
        total++;
        if (line_s != "KJKJKJKKKJJKJJKKJKKKKKJK00JJ")
            $display("FAIL a53c_line: got %s expected %s", line_s,
                     "KJKJKJKKKJJKJJKKJKKKKKJK00JJ");
        else passed++;
        total++;
        if (bs_s != "........1111111111111111....")
            $display("FAIL a53c_bitsent: got %s expected %s", bs_s,
                     "........1111111111111111....");
        else passed++;
        total++;
        if (dec != "1010010100111100")
            $display("FAIL a53c_decode: got %s expected %s", dec,
                     "1010010100111100");
        else passed++;
        total++;
        if (done !== 1'b1)
            $display("FAIL a53c_done: got %0b expected 1", done);
        else passed++;
    endtask

    task automatic test_eod_stuff();
        bytes[0] = 8'hFC;
        run_packet(1, -1, -1);
        total++;
        if (line_s != "KJKJKJKKJKKKKKKKJ00JJ")
            $display("FAIL eodstuff_line: got %s expected %s", line_s,
                     "KJKJKJKKJKKKKKKKJ00JJ");
        else passed++;
        total++;
        if (bs_s != "........11111111.....")
            $display("FAIL eodstuff_bitsent: got %s expected %s", bs_s,
                     "........11111111.....");
        else passed++;
        total++;
        if (done !== 1'b1)
            $display("FAIL eodstuff_done: got %0b expected 1", done);
        else passed++;
    endtask

    task automatic test_start_ignored();
        bytes[0] = 8'h00;
        run_packet(1, 11, -1);
        total++;
        if (line_s != "KJKJKJKKJKJKJKJK00JJ")
            $display("FAIL glitch_line: got %s expected %s", line_s,
                     "KJKJKJKKJKJKJKJK00JJ");
        else passed++;
        total++;
        if (trst_cnt != 0)
            $display("FAIL glitch_timrst: got %0d expected 0", trst_cnt);
        else passed++;
        total++;
        if (done !== 1'b1)
            $display("FAIL glitch_done: got %0b expected 1", done);
        else passed++;
    endtask

    task automatic test_reset_mid();
        bytes[0] = 8'h00;
        run_packet(1, -1, 12);
        total++;
        if (tx_busy !== 1'b1)
            $display("FAIL midrst_busy_before: got %b expected 1", tx_busy);
        else passed++;
        #2;
        n_rst = 1'b0;
        #1;
        total++;
        if ({d_plus, d_minus, tx_busy, tim_en, bit_sent} !== 5'b10000)
            $display("FAIL midrst_async: got %b expected 10000",
                     {d_plus, d_minus, tx_busy, tim_en, bit_sent});
        else passed++;
        @(negedge clk);
        total++;
        if ({d_plus, d_minus, tx_busy, tim_en, bit_sent, tim_rst}
            !== 6'b100000)
            $display("FAIL midrst_next: got %b expected 100000",
                     {d_plus, d_minus, tx_busy, tim_en, bit_sent, tim_rst});
        else passed++;
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_zero_byte();
        test_stuff_ff();
        test_two_bytes();
        test_eod_stuff();
        test_start_ignored();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
